// File: rtl/conv_input_cache_pkg.sv
// Shared constants and interface-FSM state codes for the conv input path.
package conv_input_cache_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned IMAGE_SIZE  = 8;
    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned COL_W       = $clog2(IMAGE_SIZE);

    localparam logic [DATA_WIDTH-1:0] FLOAT32_ONE = 32'h3F80_0000;

    // State codes of conv_layer_input_interface; unlisted codes mean "hold".
    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StPreload = 3'd1,
        StShift   = 3'd2,
        StBias    = 3'd5,
        StLoad    = 3'd6,
        StIdle    = 3'd7
    } state_e;

    // One image row; packed index is the column number.
    typedef logic [IMAGE_SIZE-1:0][DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/conv_input_cache.sv
// Row cache feeding the conv-kernel input shifter. Holds KERNEL_SIZE rows that are
// filled serially from external memory and presents one selected row in parallel.
module conv_input_cache
    import conv_input_cache_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,  // active-high despite the name
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [4:0]                       read_index,
    input  logic [1:0]                       preload_cycle,
    input  logic [2:0]                       current_state,
    input  logic [1:0]                       array_idx,
    output logic [IMAGE_SIZE*DATA_WIDTH-1:0] data_out_bus
);

    row_t rows_q [KERNEL_SIZE];
    row_t rows_d [KERNEL_SIZE];

    logic             idx_in_range;
    logic [COL_W-1:0] col;

    assign idx_in_range = (read_index < 5'(IMAGE_SIZE));
    assign col          = read_index[COL_W-1:0];

    // Next-state of the row storage, decoded from the interface FSM state.
    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            rows_d[r] = rows_q[r];
        end
        case (current_state)
            StInit: begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    rows_d[r] = '0;
                end
            end
            StPreload: begin
                // preload_cycle==3 never matches a row, so it writes nothing.
                if (idx_in_range) begin
                    for (int r = 0; r < KERNEL_SIZE; r++) begin
                        if (preload_cycle == 2'(r)) begin
                            rows_d[r][col] = data_in;
                        end
                    end
                end
            end
            StLoad: begin
                if (read_index == 5'd0) begin
                    // Slide the window down one line and start the new bottom row.
                    for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
                        rows_d[r] = rows_q[r+1];
                    end
                    rows_d[KERNEL_SIZE-1][0] = data_in;
                end else if (idx_in_range) begin
                    rows_d[KERNEL_SIZE-1][col] = data_in;
                end
            end
            default: begin
                // SHIFT, BIAS, IDLE and undefined codes hold contents.
            end
        endcase
    end

    // Row storage; asynchronous reset discards any partially loaded rows.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                rows_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                rows_q[r] <= rows_d[r];
            end
        end
    end

    // Combinational row select; column 0 lands in the most significant word.
    always_comb begin
        data_out_bus = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            if (array_idx == 2'(r)) begin
                for (int c = 0; c < IMAGE_SIZE; c++) begin
                    data_out_bus[(IMAGE_SIZE-1-c)*DATA_WIDTH +: DATA_WIDTH] = rows_q[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_input_cache.sv
// Directed self-checking bench for conv_input_cache.
module tb_conv_input_cache;

    localparam int DW  = 32;
    localparam int IMG = 8;
    localparam int BW  = IMG * DW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [4:0]    read_index;
    logic [1:0]    preload_cycle;
    logic [2:0]    current_state;
    logic [1:0]    array_idx;
    logic [BW-1:0] data_out_bus;

    int errors = 0;
    int checks = 0;

    conv_input_cache u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .read_index    (read_index),
        .preload_cycle (preload_cycle),
        .current_state (current_state),
        .array_idx     (array_idx),
        .data_out_bus  (data_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected row whose column c holds base+c, column 0 in the top word.
    function automatic logic [BW-1:0] row_of(input logic [DW-1:0] base);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < IMG; c++) begin
            v[(IMG-1-c)*DW +: DW] = base + DW'(c);
        end
        return v;
    endfunction

    // Advance one clock; inputs and checks happen 2 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_row(input string tag, input logic [1:0] idx,
                             input logic [BW-1:0] expv);
        array_idx = idx;
        #1;
        checks++;
        assert (data_out_bus === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, data_out_bus, expv);
        end
    endtask

    task automatic preload_all();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c <= 8; c++) begin
                current_state = 3'd1;
                preload_cycle = 2'(r);
                read_index    = 5'(c);
                data_in       = (c == 8) ? 32'hDEAD : 32'(16 * r + c);
                tick();
            end
        end
        current_state = 3'd7;
    endtask

    logic [BW-1:0] mixed;
    logic [2:0]    hold_states [5];

    initial begin
        hold_states[0] = 3'd2;
        hold_states[1] = 3'd5;
        hold_states[2] = 3'd7;
        hold_states[3] = 3'd3;
        hold_states[4] = 3'd4;

        rst_n         = 1'b0;
        data_in       = '0;
        read_index    = '0;
        preload_cycle = '0;
        current_state = 3'd7;
        array_idx     = '0;
        #3 rst_n = 1'b1;
        #4 rst_n = 1'b0;
        tick();
        check_row("reset_row0", 2'd0, '0);

        // Preload and verify all three rows.
        preload_all();
        check_row("pre_row0", 2'd0, row_of(32'h00));
        check_row("pre_row1", 2'd1, row_of(32'h10));
        check_row("pre_row2", 2'd2, row_of(32'h20));

        // Asynchronous reset in mid-cycle, observed before any clock edge.
        #1 rst_n = 1'b1;
        #1;
        check_row("arst_row0", 2'd0, '0);
        check_row("arst_row1", 2'd1, '0);
        check_row("arst_row2", 2'd2, '0);
        rst_n = 1'b0;
        tick();

        preload_all();
        check_row("pre2_row1", 2'd1, row_of(32'h10));

        // Hold states with noisy inputs leave contents untouched.
        for (int i = 0; i < 20; i++) begin
            current_state = hold_states[i % 5];
            data_in       = $urandom;
            read_index    = 5'($urandom_range(0, 31));
            preload_cycle = 2'($urandom_range(0, 3));
            tick();
        end
        current_state = 3'd7;
        check_row("hold_row0", 2'd0, row_of(32'h00));
        check_row("hold_row1", 2'd1, row_of(32'h10));
        check_row("hold_row2", 2'd2, row_of(32'h20));
        check_row("hold_idx3", 2'd3, '0);

        // PRELOAD with preload_cycle==3 must not write.
        for (int c = 0; c <= 8; c++) begin
            current_state = 3'd1;
            preload_cycle = 2'd3;
            read_index    = 5'(c);
            data_in       = 32'hBEEF;
            tick();
        end
        current_state = 3'd7;
        check_row("pc3_row0", 2'd0, row_of(32'h00));
        check_row("pc3_row1", 2'd1, row_of(32'h10));
        check_row("pc3_row2", 2'd2, row_of(32'h20));

        // LOAD beat 0 slides the window and writes only column 0 of the new row.
        current_state = 3'd6;
        read_index    = 5'd0;
        data_in       = 32'h30;
        tick();
        current_state = 3'd7;
        mixed = row_of(32'h20);
        mixed[(IMG-1)*DW +: DW] = 32'h30;
        check_row("load0_row0", 2'd0, row_of(32'h10));
        check_row("load0_row1", 2'd1, row_of(32'h20));
        check_row("load0_row2", 2'd2, mixed);

        // Remaining beats, then out-of-range beats that must be ignored.
        for (int c = 1; c <= 9; c++) begin
            current_state = 3'd6;
            read_index    = 5'(c);
            data_in       = (c >= 8) ? 32'hBAD : 32'(32'h30 + c);
            tick();
        end
        read_index    = 5'd31;
        data_in       = 32'hBAD;
        tick();
        current_state = 3'd7;
        check_row("load_row0", 2'd0, row_of(32'h10));
        check_row("load_row1", 2'd1, row_of(32'h20));
        check_row("load_row2", 2'd2, row_of(32'h30));

        // One INIT cycle clears everything.
        current_state = 3'd0;
        tick();
        current_state = 3'd7;
        check_row("init_row0", 2'd0, '0);
        check_row("init_row1", 2'd1, '0);
        check_row("init_row2", 2'd2, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
